// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter width helper.
package sub_serial_pkg;

    // Operation state: idle, shifting bits, result ready to be published.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    localparam int unsigned SUB_W_DEFAULT = 16;

    // Ceiling log2, never below 1 so the bit counter always has a bit.
    function automatic int unsigned sub_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, with borrow out.
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Borrow when x < y, or when x == y and a borrow arrives from below.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/sub_serial.sv
// Bit-serial two's-complement subtractor, diff = a - b - b_in, LSB first.
// One bit per clock through a single sub_bit_cell; results and flags are
// registered and held until the next operation completes.
// Optional build macro SUB_SAT_EN: saturate diff on signed overflow.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned    CNT_W    = sub_clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] raw_q, raw_d;
    logic             br_q, br_d;
    // Operand sign bits kept aside; the shift registers lose them.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             cell_d;
    logic             cell_bout;
    logic             accept;
    logic             ovf_w;
    logic [WIDTH-1:0] res_w;

    sub_bit_cell u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Final result and flags derived from the completed serial difference.
    always_comb begin
        ovf_w = (a_msb_q != b_msb_q) && (raw_q[WIDTH-1] != a_msb_q);
        res_w = raw_q;
`ifdef SUB_SAT_EN
        if (ovf_w) begin
            res_w = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Next-state logic: FSM, serial datapath and output register loads.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        raw_d   = raw_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        b_out_d = b_out_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        // start is honoured in IDLE and DONE, never while shifting.
        accept = start && (state_q != ST_RUN);

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = cell_bout;
                raw_d  = {cell_d, raw_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                diff_d  = res_w;
                b_out_d = br_q;
                zero_d  = (res_w == '0);
                ovf_d   = ovf_w;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture happens after DONE has read raw_q, so back-to-back is safe.
        if (accept) begin
            state_d = ST_RUN;
            a_sh_d  = a;
            b_sh_d  = b;
            br_d    = b_in;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
            raw_d   = '0;
            cnt_d   = '0;
        end

        busy_d = (state_d == ST_RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            raw_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            raw_q   <= raw_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            b_out_q <= b_out_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign b_out = b_out_q;
    assign zero  = zero_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial (WIDTH=16) with a result scoreboard.
module tb_sub_serial;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         b_out;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         b_out;
    logic         zero;
    logic         ovf;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    sub_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: full-width arithmetic, independent of the serial datapath.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbin);
        exp_t       e;
        logic [W:0] full;
        full    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        e.diff  = full[W-1:0];
        e.b_out = full[W];
        e.ovf   = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
`ifdef SUB_SAT_EN
        if (e.ovf) e.diff = ma[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        e.zero  = (e.diff == '0);
        return e;
    endfunction

    task automatic start_op(input logic [W-1:0] sa, input logic [W-1:0] sbv,
                            input logic sbin, input bit push);
        @(negedge clk);
        a     = sa;
        b     = sbv;
        b_in  = sbin;
        start = 1'b1;
        if (push) sb.push_back(model(sa, sbv, sbin));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic check_result();
        exp_t e;
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e        = sb.pop_front();
            last_exp = e;
            chk("diff", {16'd0, diff}, {16'd0, e.diff});
            chk("b_out", {31'd0, b_out}, {31'd0, e.b_out});
            chk("zero", {31'd0, zero}, {31'd0, e.zero});
            chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        end
    endtask

    task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin);
        int n;
        start_op(ra, rb, rbin, 1'b1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(n);
        chk("latency", n, 32'd17);
        check_result();
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_diff", {16'd0, diff}, {16'd0, last_exp.diff});
    endtask

    initial begin
        int n;
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        b_in  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {16'd0, diff}, 32'd0);
        chk("rst_flags", {29'd0, b_out, zero, ovf}, 32'd0);
        rst_n = 1'b1;

        // Basic, borrow, overflow and borrow-in cases.
        run_op(16'h0005, 16'h0003, 1'b0);
        chk("t1_diff_const", {16'd0, diff}, 32'h0002);
        run_op(16'h0003, 16'h0005, 1'b0);
        chk("t2_diff_const", {16'd0, diff}, 32'hFFFE);
        run_op(16'h8000, 16'h0001, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0);
        run_op(16'h1234, 16'h1233, 1'b1);
        chk("t4_zero_const", {31'd0, zero}, 32'd1);
        run_op(16'h00FF, 16'h00FF, 1'b1);
        chk("t4_ones_const", {15'd0, b_out, diff}, 32'h1FFFF);

        // Restarts while busy are ignored; start held into DONE is accepted.
        start_op(16'h0100, 16'h0001, 1'b0, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 3 || i == 10) begin
                a     = 16'hAAAA;
                b     = 16'h5555;
                b_in  = 1'b1;
                start = 1'b1;
            end else if (i == 15) begin
                a     = 16'h0050;
                b     = 16'h0008;
                b_in  = 1'b0;
                start = 1'b1;
                sb.push_back(model(16'h0050, 16'h0008, 1'b0));
            end else begin
                start = 1'b0;
            end
        end
        wait_done(n);
        chk("busy_op_latency", n + 15, 32'd17);
        check_result();
        chk("busy_op_const", {16'd0, diff}, 32'h00FF);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_hold_old", {16'd0, diff}, 32'h00FF);
        wait_done(n);
        chk("b2b_latency", n + 3, 32'd17);
        check_result();
        @(negedge clk);
        chk("b2b_done_one_cycle", {31'd0, done}, 32'd0);

        // Reset in the middle of an operation aborts it.
        start_op(16'h1111, 16'h0001, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_diff", {16'd0, diff}, 32'd0);
        chk("abort_flags", {29'd0, b_out, zero, ovf}, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("no_done_after_abort", seen, 32'd0);
        run_op(16'h0010, 16'h0001, 1'b0);
        chk("post_abort_const", {16'd0, diff}, 32'h000F);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
